// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the register-file read ports, the multiply/divide unit
// and the register-file write port.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [4:0]       dest;
    logic             busy;
    logic             done;
    logic [4:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;

    modport master (
        output start, op, opa, opb, dest,
        input  busy, done, wb_addr, wb_data
    );

    modport slave (
        input  start, op, opa, opb, dest,
        output busy, done, wb_addr, wb_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit, one bit per cycle, start/busy/done handshake.
// Define MULDIV_DIV_EN to build the DIVU/REMU datapath; otherwise divides complete with no write.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_unit_if.slave   bus
);
    localparam logic [4:0] LAST = 5'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [4:0]         count;
    logic               busy_q;
    logic               done_q;
    logic [4:0]         wb_addr_q;
    logic [WIDTH-1:0]   wb_data_q;

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opa_q;
    logic [4:0]         dest_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   shreg;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   sh_next;
    logic [WIDTH-1:0]   result;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic               opb_zero;
`endif

    // For a multiply, shreg holds the multiplier shifting right; for a divide it holds the
    // dividend shifting left while quotient bits enter from the bottom. The partial
    // remainder lives in the upper half of acc and always stays below the divisor, so
    // bit WIDTH of the 33-bit trial difference is the borrow.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opa_q & {WIDTH{shreg[0]}}};
        acc_next = {mul_sum, acc[WIDTH-1:1]};
        sh_next  = {1'b0, shreg[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        opb_zero  = (opb_q == '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], shreg[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb_q};
        div_ge    = ~div_trial[WIDTH];
        if (op_q[1]) begin
            acc_next = {(div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]), {WIDTH{1'b0}}};
            sh_next  = {shreg[WIDTH-2:0], div_ge};
        end
`endif
        result = acc_next[2*WIDTH-1:WIDTH];
        case (op_q)
            2'b00:   result = acc_next[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
            2'b10:   result = opb_zero ? {WIDTH{1'b1}} : sh_next;
            2'b11:   result = opb_zero ? opa_q : acc_next[2*WIDTH-1:WIDTH];
`endif
            default: ;
        endcase
    end

    // Operand capture on accept and one iteration per RUN cycle; no reset needed because
    // every operation starts by loading these registers.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            op_q   <= bus.op;
            opa_q  <= bus.opa;
            dest_q <= bus.dest;
            acc    <= '0;
`ifdef MULDIV_DIV_EN
            opb_q  <= bus.opb;
            shreg  <= bus.op[1] ? bus.opa : bus.opb;
`else
            shreg  <= bus.opb;
`endif
        end else if (state == RUN) begin
            acc   <= acc_next;
            shreg <= sh_next;
        end
    end

    // Control FSM with registered handshake and write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count <= '0;
`ifdef MULDIV_DIV_EN
                        state  <= RUN;
                        busy_q <= 1'b1;
`else
                        if (bus.op[1]) begin
                            state     <= DONE;
                            done_q    <= 1'b1;
                            wb_addr_q <= '0;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    count <= count + 5'd1;
                    if (count == LAST) begin
                        state     <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        wb_addr_q <= dest_q;
                        wb_data_q <= result;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done_q    <= 1'b0;
                    wb_addr_q <= '0;
                end
                default: begin
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    wb_addr_q <= '0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_data = wb_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expectations queued on stimulus, checked on done and
// again through a register-file model one cycle later.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) bus();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    logic [31:0] regs[32];
    logic [31:0] last_wb = '0;
    bit          rf_pending = 1'b0;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file downstream of the unit; register 0 is hardwired to zero.
    always @(posedge clk) begin
        if (bus.wb_addr != 5'd0) regs[bus.wb_addr] <= bus.wb_data;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic predict(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] dest);
        logic [63:0] p;
        logic [31:0] d;
        exp_t        e;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            2'd0:    d = p[31:0];
            2'd1:    d = p[63:32];
            2'd2:    d = (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: d = (b == 0) ? a : a % b;
        endcase
        if (op[1] && !DIV_EN) begin
            e.addr = 5'd0;
            e.data = last_wb;
        end else begin
            e.addr  = dest;
            e.data  = d;
            last_wb = d;
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rf_pending) begin
            checkOutput("rf_read", regs[rf_addr], rf_data);
            rf_pending = 1'b0;
        end
        if (bus.busy === 1'b1 && bus.done === 1'b1) checkOutput("busy_and_done", 1, 0);
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("wb_addr", bus.wb_addr, mon_e.addr);
                checkOutput("wb_data", bus.wb_data, mon_e.data);
                rf_pending = 1'b1;
                rf_addr    = mon_e.addr;
                rf_data    = (mon_e.addr == 5'd0) ? 32'd0 : mon_e.data;
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] dest);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        bus.dest  = dest;
        predict(op, a, b, dest);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic waitDone(input int exp_busy, input string tag);
        int nb   = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
            else if (bus.busy === 1'b1) nb++;
        end
        checkOutput({tag, "_done_seen"}, seen, 1);
        checkOutput({tag, "_busy_cycles"}, nb, exp_busy);
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] dest, input string tag);
        applyStimulus(op, a, b, dest);
        waitDone((op[1] && !DIV_EN) ? 0 : 32, tag);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout at cycle %0d", cyc);
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        logic [1:0]  hop[3];
        logic [31:0] ha[3];
        logic [31:0] hb[3];
        logic [4:0]  hd[3];
        longint      prev;
        bit          seen;
        int          ndone;

        for (int r = 0; r < 32; r++) regs[r] = '0;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.opa   = '0;
        bus.opb   = '0;
        bus.dest  = '0;
        rst       = 1'b0;

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_wb_addr", bus.wb_addr, 0);
        checkOutput("reset_wb_data", bus.wb_data, 0);

        runOp(2'd0, 32'd7, 32'd6, 5'd5, "mul_7x6");
        runOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, "mulhu_max");
        runOp(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mul_max");
        runOp(2'd0, 32'h8000_0000, 32'd2, 5'd3, "mul_wrap");
        runOp(2'd2, 32'd100, 32'd7, 5'd4, "divu_100_7");
        runOp(2'd3, 32'd100, 32'd7, 5'd6, "remu_100_7");
        runOp(2'd2, 32'h1234_5678, 32'd0, 5'd7, "divu_zero");
        runOp(2'd3, 32'h1234_5678, 32'd0, 5'd8, "remu_zero");

        // A second start mid-RUN must be ignored.
        applyStimulus(2'd0, 32'd11, 32'd13, 5'd9);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.opa   = 32'hCAFE_F00D;
        bus.opb   = 32'h0BAD_BEEF;
        bus.dest  = 5'd10;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(26, "midrun_start");
        repeat (40) @(negedge clk);
        checkOutput("midrun_ignored_reg", regs[10], 0);

        runOp(2'd0, 32'd3, 32'd3, 5'd0, "dest_zero");

        // start held high: one accept every 34 cycles.
        hop = '{2'd0, 2'd1, 2'd0};
        ha  = '{32'd5, 32'hDEAD_BEEF, 32'd1000};
        hb  = '{32'd9, 32'h1234_5678, 32'd1000};
        hd  = '{5'd11, 5'd12, 5'd13};
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = hop[0];
        bus.opa   = ha[0];
        bus.opb   = hb[0];
        bus.dest  = hd[0];
        predict(hop[0], ha[0], hb[0], hd[0]);
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (bus.done === 1'b1) seen = 1'b1;
            end
            checkOutput("held_done_seen", seen, 1);
            if (k > 0) checkOutput("held_interval", 64'(cyc - prev), 34);
            prev = cyc;
            if (k < 2) begin
                bus.op   = hop[k+1];
                bus.opa  = ha[k+1];
                bus.opb  = hb[k+1];
                bus.dest = hd[k+1];
                predict(hop[k+1], ha[k+1], hb[k+1], hd[k+1]);
            end else begin
                bus.start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);

        // Reset in the middle of RUN aborts the operation.
        applyStimulus(2'd0, 32'h1234, 32'h5678, 5'd14);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        last_wb = '0;
        @(negedge clk);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_done", bus.done, 0);
        checkOutput("abort_wb_addr", bus.wb_addr, 0);
        checkOutput("abort_wb_data", bus.wb_data, 0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        checkOutput("abort_no_done", ndone, 0);
        checkOutput("abort_no_write", regs[14], 0);
        runOp(2'd0, 32'h1234, 32'h5678, 5'd14, "after_abort");

        for (int n = 0; n < 1000; n++) begin
            logic [1:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            else if ($urandom_range(0, 1) == 1) rb = $urandom;
            else rb = 32'($urandom_range(1, 1000));
            runOp(rop, ra, rb, 5'($urandom_range(0, 31)), "random");
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
